uart_tx_arb: RTL and testbench

Round-robin arbiter that shares one `UART_TX_CORE` transmitter between up to 8 byte sources. Each source presents a byte with a request/acknowledge handshake. The arbiter picks one source, latches its byte and pulses the transmitter's edge-triggered request. It then tracks the transmitter's strobe through start, data and stop bits before it grants again. It sits between the register/debug message sources and the single board TXD pin.

---
 rtl/uart_tx_arb.sv | 195 +++++++++++++++++++
 tb/tb_uart_tx_arb.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one UART transmitter between C_REQ_N byte sources.
// Define UART_TX_ARB_LOCK_EN to keep a multi-byte packet from one source contiguous.
module uart_tx_arb #(
  parameter int unsigned C_REQ_N  = 4,
  parameter int unsigned C_ACK_TO = 15
) (
  input  logic                   CK_i,
  input  logic                   ARST_i,
  input  logic [C_REQ_N-1:0]     REQs_i,
  input  logic [8*C_REQ_N-1:0]   BYTEs_i,
  input  logic [C_REQ_N-1:0]     LASTs_i,
  output logic [C_REQ_N-1:0]     ACKs_o,
  output logic [C_REQ_N-1:0]     GNTs_o,
  output logic [7:0]             TX_BYTEs_o,
  output logic                   TX_REQ_o,
  input  logic                   TX_STB_i,
  output logic                   BUSY_o,
  output logic                   ERR_o
);

  localparam int unsigned C_PW = (C_REQ_N > 1) ? $clog2(C_REQ_N) : 1;
  localparam int unsigned C_CW = $clog2(C_ACK_TO + 1);

  typedef enum logic [1:0] {StIdle, StWaitAck, StWaitDone} state_e;

  state_e              r_state, w_state_nxt;
  logic [C_PW-1:0]     r_ptr, w_ptr_nxt;
  logic [C_CW-1:0]     r_cnt, w_cnt_nxt;
  logic [C_REQ_N-1:0]  r_ack, w_ack_nxt;
  logic [C_REQ_N-1:0]  r_gnt, w_gnt_nxt;
  logic [7:0]          r_byte, w_byte_nxt;
  logic                r_req, w_req_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_err, w_err_nxt;

  logic [C_REQ_N-1:0]  w_elig;
  logic [C_REQ_N-1:0]  w_sel_oh;
  logic                w_found;
  logic                w_grant;
  logic [7:0]          w_sel_byte;
  logic [C_PW-1:0]     w_sel_ptr;

`ifdef UART_TX_ARB_LOCK_EN
  logic                r_lock, w_lock_nxt;
  logic [C_PW-1:0]     r_owner, w_owner_nxt;
  logic [C_PW-1:0]     w_sel_idx;
  logic                w_sel_last;

  // While locked only the owner may win; PTR keeps advancing underneath.
  always_comb begin
    w_elig = '0;
    for (int unsigned n = 0; n < C_REQ_N; n++) begin
      w_elig[n] = REQs_i[n] && (!r_lock || (r_owner == C_PW'(n)));
    end
  end
`else
  logic w_unused_last;
  assign w_unused_last = ^LASTs_i;
  assign w_elig = REQs_i;
`endif

  // First eligible index at or above PTR, wrapping modulo C_REQ_N.
  always_comb begin
    w_found  = 1'b0;
    w_sel_oh = '0;
    for (int unsigned i = 0; i < C_REQ_N; i++) begin
      for (int unsigned n = 0; n < C_REQ_N; n++) begin
        if (!w_found && w_elig[n] && (((32'(r_ptr) + i) % C_REQ_N) == n)) begin
          w_found     = 1'b1;
          w_sel_oh[n] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_sel_byte = '0;
    w_sel_ptr  = '0;
`ifdef UART_TX_ARB_LOCK_EN
    w_sel_idx  = '0;
    w_sel_last = 1'b0;
`endif
    for (int unsigned n = 0; n < C_REQ_N; n++) begin
      if (w_sel_oh[n]) begin
        w_sel_byte = BYTEs_i[8*n +: 8];
        w_sel_ptr  = (n + 1 == C_REQ_N) ? '0 : C_PW'(n + 1);
`ifdef UART_TX_ARB_LOCK_EN
        w_sel_idx  = C_PW'(n);
        w_sel_last = LASTs_i[n];
`endif
      end
    end
  end

  assign w_grant = (r_state == StIdle) && TX_STB_i && w_found;

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    w_ack_nxt   = '0;
    w_req_nxt   = 1'b0;
    w_gnt_nxt   = r_gnt;
    w_byte_nxt  = r_byte;
    w_busy_nxt  = r_busy;
    w_err_nxt   = r_err;
    unique case (r_state)
      StIdle: begin
        if (w_grant) begin
          w_byte_nxt  = w_sel_byte;
          w_req_nxt   = 1'b1;
          w_ack_nxt   = w_sel_oh;
          w_gnt_nxt   = w_sel_oh;
          w_busy_nxt  = 1'b1;
          w_ptr_nxt   = w_sel_ptr;
          w_cnt_nxt   = '0;
          w_state_nxt = StWaitAck;
        end
      end
      StWaitAck: begin
        if (!TX_STB_i) begin
          w_state_nxt = StWaitDone;
        end else if (r_cnt == C_CW'(C_ACK_TO - 1)) begin
          // Transmitter never started: drop the byte and flag it.
          w_cnt_nxt   = C_CW'(C_ACK_TO);
          w_err_nxt   = 1'b1;
          w_busy_nxt  = 1'b0;
          w_state_nxt = StIdle;
        end else if (r_cnt != C_CW'(C_ACK_TO)) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      StWaitDone: begin
        if (TX_STB_i) begin
          w_busy_nxt  = 1'b0;
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

`ifdef UART_TX_ARB_LOCK_EN
  always_comb begin
    w_lock_nxt  = r_lock;
    w_owner_nxt = r_owner;
    if (w_grant) begin
      w_lock_nxt  = !w_sel_last;
      w_owner_nxt = w_sel_idx;
    end
  end

  always_ff @(posedge CK_i or posedge ARST_i) begin
    if (ARST_i) begin
      r_lock  <= 1'b0;
      r_owner <= '0;
    end else begin
      r_lock  <= w_lock_nxt;
      r_owner <= w_owner_nxt;
    end
  end
`endif

  always_ff @(posedge CK_i or posedge ARST_i) begin
    if (ARST_i) begin
      r_state <= StIdle;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_ack   <= '0;
      r_gnt   <= '0;
      r_byte  <= '0;
      r_req   <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ack   <= w_ack_nxt;
      r_gnt   <= w_gnt_nxt;
      r_byte  <= w_byte_nxt;
      r_req   <= w_req_nxt;
      r_busy  <= w_busy_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign ACKs_o     = r_ack;
  assign GNTs_o     = r_gnt;
  assign TX_BYTEs_o = r_byte;
  assign TX_REQ_o   = r_req;
  assign BUSY_o     = r_busy;
  assign ERR_o      = r_err;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: vector table, directed corner sequences and randomized rounds
// against a queue-based round-robin model, with a behavioural transmitter.
module tb_uart_tx_arb;

  localparam int N = 4;
  typedef logic [7:0] u8_t;

  logic           clk = 1'b0;
  logic           arst = 1'b1;
  logic [N-1:0]   reqs = '0;
  logic [N-1:0]   lasts = '1;
  logic [8*N-1:0] bytes = '0;
  logic [N-1:0]   ack, gnt;
  logic [7:0]     tx_byte;
  logic           tx_req, busy, err, stb;

  logic           tie_hi = 1'b0;
  logic           tx_stb = 1'b1;
  logic           tx_req_q = 1'b0;
  int             tx_cnt = 0;
  int             frame = 10;
  int             adj_err = 0;
  int             ovl_err = 0;
  u8_t            rx_q[$];
  logic [N-1:0]   rxg_q[$];

  u8_t            src_q[N][$];
  logic           en[N];
  logic           last_mode = 1'b0;
  int             ack_bad = 0;
  int             n_checks = 0;
  int             n_fail = 0;

  assign stb = tie_hi | tx_stb;

  uart_tx_arb #(.C_REQ_N(N), .C_ACK_TO(15)) dut (
    .CK_i(clk), .ARST_i(arst), .REQs_i(reqs), .BYTEs_i(bytes), .LASTs_i(lasts),
    .ACKs_o(ack), .GNTs_o(gnt), .TX_BYTEs_o(tx_byte), .TX_REQ_o(tx_req),
    .TX_STB_i(stb), .BUSY_o(busy), .ERR_o(err)
  );

  always #5 clk = ~clk;

  // Transmitter: rising edge of TX_REQ starts a frame, strobe low for 'frame' cycles.
  always @(posedge clk) begin
    tx_req_q <= tx_req;
    if (tx_req && tx_req_q) adj_err <= adj_err + 1;
    if (tx_cnt != 0) begin
      if (tx_req && !tx_req_q) ovl_err <= ovl_err + 1;
      tx_cnt <= tx_cnt - 1;
      if (tx_cnt == 1) tx_stb <= 1'b1;
    end else if (tx_req && !tx_req_q && !tie_hi) begin
      tx_stb <= 1'b0;
      tx_cnt <= frame;
      rx_q.push_back(tx_byte);
      rxg_q.push_back(gnt);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (ack != '0 && (!$onehot(ack) || ack != gnt || !tx_req || !busy)) ack_bad++;
  endtask

  // Sources pop on ACK and present their next byte in the following cycle.
  task automatic drive();
    for (int n = 0; n < N; n++) begin
      if (ack[n] && src_q[n].size() > 0) void'(src_q[n].pop_front());
      reqs[n]          = en[n] && (src_q[n].size() > 0);
      bytes[8*n +: 8]  = (src_q[n].size() > 0) ? src_q[n][0] : 8'h00;
      lasts[n]         = last_mode ? (src_q[n].size() == 1) : 1'b1;
    end
  endtask

  function automatic bit srcs_empty();
    for (int n = 0; n < N; n++) if (src_q[n].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic do_reset();
    arst = 1'b1;
    reqs = '0;
    last_mode = 1'b0;
    for (int n = 0; n < N; n++) begin
      src_q[n].delete();
      en[n] = 1'b1;
    end
    #1;
    chk("reset_outs", {ack, gnt, tx_byte, tx_req, busy, err}, '0);
    repeat (2) @(posedge clk);
    #1;
    arst = 1'b0;
  endtask

  task automatic wait_tx_idle();
    for (int i = 0; i < 500 && !tx_stb; i++) tick();
  endtask

  // Model: round-robin from index 0 over sources with bytes left.
  task automatic run_round(input int budget);
    u8_t          mq[N][$];
    u8_t          exp_b[$];
    logic [N-1:0] exp_g[$];
    int           ptr = 0;
    bit           done = 1'b0;
    bit           any;
    for (int n = 0; n < N; n++) mq[n] = src_q[n];
    do begin
      any = 1'b0;
      for (int i = 0; i < N && !any; i++) begin
        int k = (ptr + i) % N;
        if (mq[k].size() > 0) begin
          exp_b.push_back(mq[k].pop_front());
          exp_g.push_back(N'(1) << k);
          ptr = (k + 1) % N;
          any = 1'b1;
        end
      end
    end while (any);
    rx_q.delete();
    rxg_q.delete();
    drive();
    for (int c = 0; c < budget && !done; c++) begin
      tick();
      drive();
      if (srcs_empty() && !busy && tx_stb && rx_q.size() == exp_b.size()) done = 1'b1;
    end
    chk("round_done", done, 1);
    chk("round_count", rx_q.size(), exp_b.size());
    for (int i = 0; i < exp_b.size() && i < rx_q.size(); i++) begin
      chk("round_byte", rx_q[i], exp_b[i]);
      chk("round_gnt", rxg_q[i], exp_g[i]);
    end
  endtask

  typedef struct {
    logic [3:0]  reqs;
    logic [31:0] bytes;
    logic [3:0]  gnt;
    logic [7:0]  b;
    logic        req;
  } vec_t;

  initial begin
    vec_t vt[6];
    u8_t  exp_all[8];
    u8_t  exp_13[6];
    bit   got;
    int   errk;
    logic busy14;
    logic prev_stb;
    bit   early;

    vt[0] = '{4'b0100, 32'h0041_0000, 4'b0100, 8'h41, 1'b1};
    vt[1] = '{4'b1111, 32'h3332_3130, 4'b0001, 8'h30, 1'b1};
    vt[2] = '{4'b1010, 32'h3332_3130, 4'b0010, 8'h31, 1'b1};
    vt[3] = '{4'b1000, 32'h4433_2211, 4'b1000, 8'h44, 1'b1};
    vt[4] = '{4'b1100, 32'hA5B6_C7D8, 4'b0100, 8'hB6, 1'b1};
    vt[5] = '{4'b0000, 32'hFFFF_FFFF, 4'b0000, 8'h00, 1'b0};

    for (int v = 0; v < 6; v++) begin
      do_reset();
      wait_tx_idle();
      reqs  = vt[v].reqs;
      bytes = vt[v].bytes;
      tick();
      chk("vec_ack", ack, vt[v].gnt);
      chk("vec_gnt", gnt, vt[v].gnt);
      chk("vec_byte", tx_byte, vt[v].b);
      chk("vec_txreq", tx_req, vt[v].req);
      chk("vec_busy", busy, vt[v].req);
      reqs = '0;
      tick();
      chk("vec_pulse", {ack, tx_req}, '0);
    end

    // All four sources continuously: strict rotation.
    do_reset();
    wait_tx_idle();
    frame = 10;
    for (int n = 0; n < N; n++) src_q[n] = '{u8_t'(8'h30 + n), u8_t'(8'h30 + n)};
    run_round(1000);
    exp_all = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h30, 8'h31, 8'h32, 8'h33};
    chk("rr_all_len", rx_q.size(), 8);
    for (int i = 0; i < 8; i++) chk("rr_all", (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_all[i]);

    // Sources 1 and 3: pointer wraps from 3 back to 1.
    do_reset();
    wait_tx_idle();
    src_q[1] = '{8'h11, 8'h12, 8'h13};
    src_q[3] = '{8'h31, 8'h32, 8'h33};
    run_round(1000);
    exp_13 = '{8'h11, 8'h31, 8'h12, 8'h32, 8'h13, 8'h33};
    chk("rr_13_len", rx_q.size(), 6);
    for (int i = 0; i < 6; i++) chk("rr_13", (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_13[i]);

    // No transmitter: acknowledge timeout after 15 cycles in WAIT_ACK.
    do_reset();
    wait_tx_idle();
    tie_hi = 1'b1;
    src_q[0] = '{8'h55};
    drive();
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      tick();
      if (ack[0]) got = 1'b1;
      drive();
    end
    chk("to_ack", got, 1);
    errk = 0;
    busy14 = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      drive();
      if (err && errk == 0) errk = k;
      if (k == 14) busy14 = busy;
    end
    chk("to_cycles", errk, 15);
    chk("to_busy_before", busy14, 1);
    chk("to_busy_after", busy, 0);
    tie_hi = 1'b0;
    src_q[1] = '{8'h77};
    run_round(500);
    chk("err_sticky", err, 1);
    do_reset();
    chk("err_cleared", err, 0);

    // Reset during WAIT_DONE; re-grant must wait for the live transmitter.
    wait_tx_idle();
    frame = 40;
    src_q[2] = '{8'hA0, 8'hA1};
    drive();
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      tick();
      if (ack[2]) got = 1'b1;
      drive();
    end
    chk("mid_first_ack", got, 1);
    repeat (5) begin
      tick();
      drive();
    end
    chk("mid_busy", busy, 1);
    arst = 1'b1;
    #1;
    chk("mid_reset_outs", {ack, gnt, tx_byte, tx_req, busy, err}, '0);
    repeat (2) @(posedge clk);
    #1;
    arst = 1'b0;
    got = 1'b0;
    early = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      prev_stb = tx_stb;
      tick();
      if (ack != '0) begin
        got = 1'b1;
        if (!prev_stb) early = 1'b1;
        chk("mid_byte", tx_byte, 8'hA1);
      end
      drive();
    end
    chk("mid_regrant", got, 1);
    chk("mid_early", early, 0);

`ifdef UART_TX_ARB_LOCK_EN
    // Packet lock: source 1 keeps the channel until its LAST byte.
    do_reset();
    wait_tx_idle();
    frame = 6;
    last_mode = 1'b1;
    src_q[1] = '{8'hA1, 8'hA2, 8'hA3};
    src_q[0] = '{8'hB1, 8'hB2};
    en[0] = 1'b0;
    rx_q.delete();
    drive();
    got = 1'b0;
    for (int c = 0; c < 1000 && !got; c++) begin
      tick();
      if (ack[1]) en[0] = 1'b1;
      drive();
      if (srcs_empty() && !busy && tx_stb && rx_q.size() == 5) got = 1'b1;
    end
    chk("lock_done", got, 1);
    exp_all = '{8'hA1, 8'hA2, 8'hA3, 8'hB1, 8'hB2, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 5; i++) chk("lock_order", (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_all[i]);
`endif

    // Randomized rounds against the round-robin model.
    for (int r = 0; r < 8; r++) begin
      do_reset();
      wait_tx_idle();
      frame = $urandom_range(2, 14);
      for (int n = 0; n < N; n++) begin
        int len = $urandom_range(0, 5);
        for (int j = 0; j < len; j++) src_q[n].push_back(u8_t'($urandom));
      end
      run_round(2000);
    end

    chk("ack_proto", ack_bad, 0);
    chk("tx_req_gap", adj_err, 0);
    chk("tx_overlap", ovl_err, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
